seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
- Parametrised, time-multiplexed driver for a bank of common-anode/cathode 7-segment digits.
- Replaces per-digit combinational decode with one shared registered decoder, scanned across DIGITS anodes.
- Supports full hex (0-F), per-digit decimal point, per-digit blanking, optional leading-zero suppression, and tear-free frame-synchronous value update.
- Sits between CPU debug/status registers and board display pins.

Parameters:
- DIGITS, 8, number of digits scanned (1..16).
- DIV, 100000, clk cycles each digit stays lit (>=2).
- SEG_ACTIVE_LOW, 1, 1: segment/dp outputs low = lit; 0: high = lit.
- AN_ACTIVE_LOW, 1, 1: anode low = selected; 0: high = selected.
- LZ_BLANK, 0, 1: blank leading zero digits, except digit 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  one-cycle strobe; capture value/dp_in/blank_in
- value  in  4*DIGITS  nibble i = hex digit i (digit 0 = rightmost, LSB)
- dp_in  in  DIGITS  bit i lights dp of digit i
- blank_in  in  DIGITS  bit i forces digit i fully dark (segments and dp)
- seg  out  7  {g,f,e,d,c,b,a}
- dp  out  1  decimal point of current digit
- an  out  DIGITS  one-hot (per polarity) digit select
- frame_done  out  1  one-cycle pulse when last digit's slot ends

Behaviour:
- Reset (async assert, sync-to-clk deassert is board's job):
  - div counter=0; digit index=0; pending and display registers=0; pending flag=0; frame_done=0.
  - seg/dp=unlit level; an=all deselected.
- Divider counts 0..DIV-1. On count==DIV-1 ("tick"), the count wraps to 0 and the index advances; the index wraps DIGITS-1 -> 0.
- frame_done=1 for exactly the cycle after the tick where the index wraps to 0.
- Load path:
  - load=1 copies value/dp_in/blank_in to the pending registers and sets the pending flag.
  - Multiple loads in a frame: last wins.
- Frame update:
  - On a tick with index==DIGITS-1, if the pending flag is set, pending copies to the display registers and the flag clears.
  - load on that same cycle: the incoming load data goes directly to the display registers and the flag stays clear.
  - The display never changes mid-frame.
- Outputs are registered, computed each cycle from the current index and display registers. Latency is 1 clk from index change to pins.
- Decode, active-high g..a: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. Invert if SEG_ACTIVE_LOW. dp follows the same polarity.
- Blank: seg and dp unlit; an still selects the digit (constant brightness duty).
- LZ_BLANK=1: digit i (i>0) is blanked if it and all higher nibbles are 0. Digit 0 is always shown. dp_in=1 on a digit cancels suppression for that digit and all lower digits.
- DIGITS=1: index constant 0; frame_done pulses every DIV cycles.
- Reset mid-frame: all state returns to reset values immediately; pending data is lost.

Test Plan (DIGITS=4, DIV=4, SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1 unless stated):
- Reset: hold rst_n=0 then release -> seg=7F, dp=1, an=F during reset. First registered cycle after release: an=E.
- Scan: load value=16'h12AF, dp_in=0 -> after the next frame_done, an walks E,D,B,7, each held 4 clks. seg=~71,~77,~5B,~06 (0E,08,24,79), repeating.
- Tear-free update: load 16'h0000 mid-frame while 16'h1234 is displayed -> remaining digits of the current frame still show 1234; the next frame shows 0000.
- Load coinciding with last-digit tick: load 16'h5555 on that exact cycle -> the next frame shows 5 on all digits; no extra frame of stale data.
- Blank/dp: blank_in=4'b0100, dp_in=4'b0001 -> digit 2 seg=7F, dp=1 with an=B still asserted. Digit 0 dp=0.
- LZ_BLANK=1, value=16'h0050 -> digits 3 and 2 dark, digits 1 and 0 show 5 and 0. With dp_in=4'b0100, digit 2 shows 0 with dp lit.

Source files
------------

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed 7-segment driver.
// One shared registered decoder is scanned across DIGITS anodes. Each digit
// stays lit for DIV clocks. The display contents change only at frame
// boundaries, so a frame never shows a mix of old and new data.
//
// load is a one-cycle strobe with no back-pressure. On every cycle where
// load=1, value/dp_in/blank_in are captured, and the last capture before a
// frame boundary wins. A load on the boundary cycle itself goes straight to
// the display.
module seg_scan_display #(
    parameter int DIGITS         = 8,
    parameter int DIV            = 100000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int LZ_BLANK       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam bit SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam bit AN_INV  = (AN_ACTIVE_LOW != 0);
    localparam logic [6:0]        SEG_OFF = SEG_INV ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = SEG_INV;
    localparam logic [DIGITS-1:0] AN_OFF  = AN_INV ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   pend_val, disp_val;
    logic [DIGITS-1:0]     pend_dp, disp_dp;
    logic [DIGITS-1:0]     pend_bl, disp_bl;
    logic                  pend_flag;

    logic tick, last_digit, frame_end;
    assign tick       = (cnt == CW'(DIV - 1));
    assign last_digit = (idx == IW'(DIGITS - 1));
    assign frame_end  = tick & last_digit;

    // Hex to active-high {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    // Slot divider and digit index; frame_done marks the cycle after the final slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (tick) begin
                cnt <= '0;
                idx <= last_digit ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Pending capture and frame-synchronous transfer to the display registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val  <= '0;
            pend_dp   <= '0;
            pend_bl   <= '0;
            pend_flag <= 1'b0;
            disp_val  <= '0;
            disp_dp   <= '0;
            disp_bl   <= '0;
        end else if (load && frame_end) begin
            disp_val  <= value;
            disp_dp   <= dp_in;
            disp_bl   <= blank_in;
            pend_flag <= 1'b0;
        end else if (load) begin
            pend_val  <= value;
            pend_dp   <= dp_in;
            pend_bl   <= blank_in;
            pend_flag <= 1'b1;
        end else if (frame_end && pend_flag) begin
            disp_val  <= pend_val;
            disp_dp   <= pend_dp;
            disp_bl   <= pend_bl;
            pend_flag <= 1'b0;
        end
    end

    // Leading-zero mask: walk down from the top nibble while it stays zero with no dp.
    logic [DIGITS-1:0] lz_mask;
    logic              zero_run;
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run & (disp_val[4*i +: 4] == 4'h0) & ~disp_dp[i];
            lz_mask[i] = (LZ_BLANK != 0) && (i != 0) && zero_run;
        end
    end

    logic [3:0]        cur_nib;
    logic              cur_dark;
    logic [6:0]        seg_lit;
    logic              dp_lit;
    logic [DIGITS-1:0] an_sel;
    assign cur_nib  = disp_val[{idx, 2'b00} +: 4];
    assign cur_dark = disp_bl[idx] | lz_mask[idx];
    assign seg_lit  = cur_dark ? 7'h00 : decode(cur_nib);
    assign dp_lit   = ~cur_dark & disp_dp[idx];
    assign an_sel   = DIGITS'(1) << idx;

    // Registered pin drivers, one clock behind the index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            dp  <= DP_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= SEG_INV ? ~seg_lit : seg_lit;
            dp  <= SEG_INV ? ~dp_lit : dp_lit;
            an  <= AN_INV ? ~an_sel : an_sel;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display (DIGITS=4, DIV=4, active-low pins).
// Two instances share stimulus: one plain, one with leading-zero blanking.
// A frame-level reference model pushes the expected pins for every clock,
// and a monitor pops and compares them on the falling edge.
module tb_seg_scan_display;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int FRAME  = DIGITS * DIV;
    localparam int W      = 26;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [6:0]  seg, seg_z;
    logic        dp, dp_z;
    logic [3:0]  an, an_z;
    logic        frame_done, frame_done_z;

    seg_scan_display #(.DIGITS(DIGITS), .DIV(DIV), .SEG_ACTIVE_LOW(1),
                       .AN_ACTIVE_LOW(1), .LZ_BLANK(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .blank_in(blank_in), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done));

    seg_scan_display #(.DIGITS(DIGITS), .DIV(DIV), .SEG_ACTIVE_LOW(1),
                       .AN_ACTIVE_LOW(1), .LZ_BLANK(1)) u_dut_lz (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .blank_in(blank_in), .seg(seg_z), .dp(dp_z), .an(an_z), .frame_done(frame_done_z));

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int total  = 0;
    int passed = 0;
    int cyc    = 0;   // rising edges since reset release

    // Frame-level model: what the display shows this frame, and the newest load.
    logic [15:0] m_val, n_val;
    logic [3:0]  m_dp, n_dp, m_bl, n_bl;
    bit          n_new;

    // Pins expected while digit d of the current frame is lit: {seg, dp}.
    function automatic logic [7:0] digit_pins(input int d, input bit lz);
        logic [6:0] s;
        bit dark, zero_above;
        dark = m_bl[d];
        if (lz && d > 0) begin
            zero_above = 1'b1;
            for (int j = d; j < DIGITS; j++)
                if (m_val[4*j +: 4] != 4'h0 || m_dp[j]) zero_above = 1'b0;
            if (zero_above) dark = 1'b1;
        end
        s = dark ? 7'h00 : SEG_TAB[m_val[4*d +: 4]];
        return {~s, ~(!dark && m_dp[d])};
    endfunction

    // Model: one expected entry per rising edge out of reset.
    initial begin
        logic [7:0] p, pz;
        logic [3:0] a;
        int d;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_val = '0; m_dp = '0; m_bl = '0;
                n_val = '0; n_dp = '0; n_bl = '0; n_new = 1'b0;
                cyc = 0;
                exp_q.delete();
            end else begin
                d  = (cyc / DIV) % DIGITS;
                p  = digit_pins(d, 1'b0);
                pz = digit_pins(d, 1'b1);
                a  = ~(4'b0001 << d);
                exp_q.push_back({(cyc % FRAME) == FRAME - 1, a, p, a, pz, (cyc % FRAME) == FRAME - 1});
                if (load) begin
                    n_val = value; n_dp = dp_in; n_bl = blank_in; n_new = 1'b1;
                end
                if ((cyc % FRAME) == FRAME - 1 && n_new) begin
                    m_val = n_val; m_dp = n_dp; m_bl = n_bl; n_new = 1'b0;
                end
                cyc++;
            end
        end
    end

    // Monitor: compare pins against the oldest expectation on each falling edge.
    initial begin
        logic [W-1:0] e, got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {frame_done, an, seg, dp, an_z, seg_z, dp_z, frame_done_z};
                total++;
                if (got === e) passed++;
                else $display("FAIL pins cyc=%0d: got fd=%b an=%h seg=%h dp=%b | lz an=%h seg=%h dp=%b fd=%b ; want fd=%b an=%h seg=%h dp=%b | lz an=%h seg=%h dp=%b fd=%b",
                              cyc, got[25], got[24:21], got[20:14], got[13], got[12:9], got[8:2], got[1], got[0],
                              e[25], e[24:21], e[20:14], e[13], e[12:9], e[8:2], e[1], e[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] bl);
        load = 1'b1; value = v; dp_in = dpv; blank_in = bl;
        idle(1);
        load = 1'b0;
    endtask

    task automatic wait_slot(input int pos);
        while ((cyc % FRAME) != pos) idle(1);
    endtask

    task automatic check_reset(input string name);
        total++;
        if ({seg, dp, an, frame_done, seg_z, dp_z, an_z, frame_done_z} ===
            {7'h7F, 1'b1, 4'hF, 1'b0, 7'h7F, 1'b1, 4'hF, 1'b0}) passed++;
        else $display("FAIL %s: got seg=%h dp=%b an=%h fd=%b lz seg=%h dp=%b an=%h fd=%b ; want seg=7f dp=1 an=f fd=0",
                      name, seg, dp, an, frame_done, seg_z, dp_z, an_z, frame_done_z);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] v;
        logic [3:0]  dpv, bl;

        // Reset held: pins at unlit / deselected levels.
        repeat (3) @(negedge clk);
        check_reset("reset_hold");
        #2 rst_n = 1'b1;
        idle(4);

        // Scan of 12AF across two full frames.
        do_load(16'h12AF, 4'h0, 4'h0);
        idle(2 * FRAME + 4);

        // Tear-free: 1234 showing, load 0000 mid-frame.
        do_load(16'h1234, 4'h0, 4'h0);
        wait_slot(0);
        idle(6);
        do_load(16'h0000, 4'h0, 4'h0);
        idle(2 * FRAME);

        // Load landing exactly on the last-digit tick.
        wait_slot(FRAME - 1);
        do_load(16'h5555, 4'h0, 4'h0);
        idle(FRAME + 2);

        // Several loads in one frame: last wins.
        do_load(16'h1111, 4'h1, 4'h0);
        do_load(16'h2222, 4'h2, 4'h0);
        do_load(16'h9C3E, 4'h8, 4'h0);
        idle(2 * FRAME);

        // Blanking and decimal point.
        do_load(16'h8888, 4'b0001, 4'b0100);
        idle(2 * FRAME);

        // Leading-zero suppression, then dp cancelling it.
        do_load(16'h0050, 4'b0000, 4'b0000);
        idle(2 * FRAME);
        do_load(16'h0050, 4'b0100, 4'b0000);
        idle(2 * FRAME);
        do_load(16'h0000, 4'b0000, 4'b0000);
        idle(2 * FRAME);

        // Randomized loads, biased toward leading zeros and sparse blanking.
        for (int i = 0; i < 40; i++) begin
            v   = 16'($urandom) >> (4 * $urandom_range(0, 3));
            dpv = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            bl  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            do_load(v, dpv, bl);
            idle($urandom_range(0, 20));
        end
        idle(2 * FRAME);

        // Reset mid-frame with a load pending: everything returns to reset values.
        do_load(16'h4321, 4'hF, 4'h0);
        wait_slot(9);
        rst_n = 1'b0;
        #1;
        check_reset("reset_async");
        idle(2);
        check_reset("reset_held_mid");
        rst_n = 1'b1;
        idle(2 * FRAME + 3);

        // Every expectation consumed.
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL queue_drain: got %0d entries left, want 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
